// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle ARMv4 sequencing controller.
package multicycle_pkg;

  // State encodings are exported on the State debug port, so values are fixed.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } ctrl_state_t;

  // Instruction class, taken from instruction bits [27:26].
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_B     = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // Result bus source.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU B operand source.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Funct bit positions.
  localparam int FUNCT_I = 5;
  localparam int FUNCT_L = 0;

  // Datapath control bundle produced by the output decode.
  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       undef;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
  } ctrl_out_t;

  // Selects used while fetching: PC on the address bus, PC+4 through the ALU.
  // Also used as the quiescent pattern held during reset.
  function automatic ctrl_out_t fetch_selects();
    ctrl_out_t o;
    o            = '0;
    o.adr_src    = 1'b0;
    o.alu_src_a  = 1'b1;
    o.alu_src_b  = SRCB_FOUR;
    o.result_src = RES_ALU;
    o.alu_op     = 1'b0;
    return o;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore sequencing controller for the multicycle ARMv4 datapath.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | register read, ALU forms PC+8, dispatch on Op/Funct
// MEMADR   | ALU computes Rn + ExtImm memory address
// MEMREAD  | load data read from ALUOut address, wait for ready
// MEMWB    | loaded data written to register file
// MEMWRITE | store to ALUOut address, MemW held until ready
// EXECR    | data-processing with register operand
// EXECI    | data-processing with immediate operand
// ALUWB    | ALU result written to register file
// BRANCH   | PC + ExtImm loaded into PC if condition passes
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       Branch,
  output logic       RegW,
  output logic       MemW,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       Undef,
  output logic [3:0] State
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  ctrl_out_t   ctrl;

  // Next-state selection; Op/Funct only matter in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[FUNCT_I] ? S_EXECI : S_EXECR;
          OP_B:    state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d = Funct[FUNCT_L] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        state_d = S_ALUWB;
      end
      S_MEMWB, S_ALUWB, S_BRANCH: begin
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Moore output decode; reset masks all strobes and parks selects at FETCH.
  always_comb begin
    ctrl = '0;
    if (reset) begin
      ctrl = fetch_selects();
    end else begin
      unique case (state_q)
        S_FETCH: begin
          ctrl          = fetch_selects();
          ctrl.ir_write = MemReady;
          ctrl.next_pc  = MemReady;
        end
        S_DECODE: begin
          // ALU forms PC+8 for the R15 read while the register file decodes.
          ctrl       = fetch_selects();
          ctrl.undef = (Op == OP_UNDEF);
        end
        S_MEMADR: begin
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = 1'b0;
        end
        S_MEMREAD: begin
          ctrl.adr_src    = 1'b1;
          ctrl.result_src = RES_ALUOUT;
        end
        S_MEMWB: begin
          ctrl.result_src = RES_DATA;
          ctrl.reg_w      = 1'b1;
        end
        S_MEMWRITE: begin
          // Write strobe held for the whole stall so memory sees a stable request.
          ctrl.adr_src    = 1'b1;
          ctrl.result_src = RES_ALUOUT;
          ctrl.mem_w      = 1'b1;
        end
        S_EXECR: begin
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = 1'b1;
        end
        S_EXECI: begin
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = 1'b1;
        end
        S_ALUWB: begin
          ctrl.result_src = RES_ALUOUT;
          ctrl.reg_w      = 1'b1;
        end
        S_BRANCH: begin
          // PC load itself is gated by the condition check outside this block.
          ctrl.alu_src_a  = 1'b0;
          ctrl.alu_src_b  = SRCB_IMM;
          ctrl.result_src = RES_ALU;
          ctrl.alu_op     = 1'b0;
          ctrl.branch     = 1'b1;
        end
        default: begin
          ctrl = '0;
        end
      endcase
    end
  end

  // Port mapping; ImmSrc/RegSrc follow Op directly with no state dependence.
  always_comb begin
    IRWrite   = ctrl.ir_write;
    NextPC    = ctrl.next_pc;
    Branch    = ctrl.branch;
    RegW      = ctrl.reg_w;
    MemW      = ctrl.mem_w;
    Undef     = ctrl.undef;
    AdrSrc    = ctrl.adr_src;
    ResultSrc = ctrl.result_src;
    ALUSrcA   = ctrl.alu_src_a;
    ALUSrcB   = ctrl.alu_src_b;
    ALUOp     = ctrl.alu_op;
    ImmSrc    = Op;
    RegSrc    = {(Op == OP_MEM), (Op == OP_B)};
    State     = state_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, NextPC, Branch, RegW, MemW, AdrSrc, ALUSrcA, ALUOp, Undef;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0] State;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .Branch(Branch), .RegW(RegW), .MemW(MemW),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Undef(Undef), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes {IRWrite,NextPC,Branch,RegW,MemW,Undef}
  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_FET  = 6'b110000;
  localparam logic [5:0] ST_BR   = 6'b001000;
  localparam logic [5:0] ST_RW   = 6'b000100;
  localparam logic [5:0] ST_MW   = 6'b000010;
  localparam logic [5:0] ST_UD   = 6'b000001;
  // Selects {AdrSrc,ResultSrc[1:0],ALUSrcA,ALUSrcB[1:0],ALUOp}
  localparam logic [6:0] SL_FETCH = 7'b0_10_1_10_0;
  localparam logic [6:0] SL_DEC   = 7'b0_10_1_10_0;
  localparam logic [6:0] SL_MADR  = 7'b0_00_0_01_0;
  localparam logic [6:0] SL_MRD   = 7'b1_00_0_00_0;
  localparam logic [6:0] SL_MWB   = 7'b0_01_0_00_0;
  localparam logic [6:0] SL_MWR   = 7'b1_00_0_00_0;
  localparam logic [6:0] SL_EXR   = 7'b0_00_0_00_1;
  localparam logic [6:0] SL_EXI   = 7'b0_00_0_01_1;
  localparam logic [6:0] SL_AWB   = 7'b0_00_0_00_0;
  localparam logic [6:0] SL_BR    = 7'b0_10_0_01_0;

  typedef struct {
    logic       rst;
    logic [1:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic [3:0] st;
    logic [5:0] strb;
    logic [6:0] sel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [1:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [3:0] st, input logic [5:0] strb,
                     input logic [6:0] sel);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.rdy = rdy;
    v.st = st; v.strb = strb; v.sel = sel;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] observed();
    return {State, IRWrite, NextPC, Branch, RegW, MemW, Undef,
            AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  endfunction

  int memw_cnt, regw_cnt, cyc;
  logic bad_strobe;
  logic [1:0] exp_rs;

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'b0; MemReady = 1'b1;
    @(posedge clk); #1;

    // reset state
    add(1, 2'b00, 6'h00, 1, 4'd0, ST_NONE, SL_FETCH);
    // DP register: 0,1,6,8
    add(0, 2'b00, 6'h00, 1, 4'd0, ST_FET,  SL_FETCH);
    add(0, 2'b00, 6'h00, 1, 4'd1, ST_NONE, SL_DEC);
    add(0, 2'b00, 6'h00, 1, 4'd6, ST_NONE, SL_EXR);
    add(0, 2'b00, 6'h00, 1, 4'd8, ST_RW,   SL_AWB);
    // LDR with two stall cycles in MEMREAD
    add(0, 2'b01, 6'h01, 1, 4'd0, ST_FET,  SL_FETCH);
    add(0, 2'b01, 6'h01, 1, 4'd1, ST_NONE, SL_DEC);
    add(0, 2'b01, 6'h01, 1, 4'd2, ST_NONE, SL_MADR);
    add(0, 2'b01, 6'h01, 0, 4'd3, ST_NONE, SL_MRD);
    add(0, 2'b01, 6'h01, 0, 4'd3, ST_NONE, SL_MRD);
    add(0, 2'b01, 6'h01, 1, 4'd3, ST_NONE, SL_MRD);
    add(0, 2'b01, 6'h01, 1, 4'd4, ST_RW,   SL_MWB);
    // STR with three stall cycles in MEMWRITE
    add(0, 2'b01, 6'h00, 1, 4'd0, ST_FET,  SL_FETCH);
    add(0, 2'b01, 6'h00, 1, 4'd1, ST_NONE, SL_DEC);
    add(0, 2'b01, 6'h00, 1, 4'd2, ST_NONE, SL_MADR);
    add(0, 2'b01, 6'h00, 0, 4'd5, ST_MW,   SL_MWR);
    add(0, 2'b01, 6'h00, 0, 4'd5, ST_MW,   SL_MWR);
    add(0, 2'b01, 6'h00, 0, 4'd5, ST_MW,   SL_MWR);
    add(0, 2'b01, 6'h00, 1, 4'd5, ST_MW,   SL_MWR);
    // Branch
    add(0, 2'b10, 6'h00, 1, 4'd0, ST_FET,  SL_FETCH);
    add(0, 2'b10, 6'h00, 1, 4'd1, ST_NONE, SL_DEC);
    add(0, 2'b10, 6'h00, 1, 4'd9, ST_BR,   SL_BR);
    // Undefined
    add(0, 2'b11, 6'h00, 1, 4'd0, ST_FET,  SL_FETCH);
    add(0, 2'b11, 6'h00, 1, 4'd1, ST_UD,   SL_DEC);
    // DP immediate, preceded by a one-cycle fetch stall
    add(0, 2'b00, 6'h20, 0, 4'd0, ST_NONE, SL_FETCH);
    add(0, 2'b00, 6'h20, 1, 4'd0, ST_FET,  SL_FETCH);
    add(0, 2'b00, 6'h20, 1, 4'd1, ST_NONE, SL_DEC);
    add(0, 2'b00, 6'h20, 1, 4'd7, ST_NONE, SL_EXI);
    add(0, 2'b00, 6'h20, 1, 4'd8, ST_RW,   SL_AWB);
    // Reset during MEMWRITE stall
    add(0, 2'b01, 6'h00, 1, 4'd0, ST_FET,  SL_FETCH);
    add(0, 2'b01, 6'h00, 1, 4'd1, ST_NONE, SL_DEC);
    add(0, 2'b01, 6'h00, 1, 4'd2, ST_NONE, SL_MADR);
    add(0, 2'b01, 6'h00, 0, 4'd5, ST_MW,   SL_MWR);
    add(1, 2'b01, 6'h00, 0, 4'd5, ST_NONE, SL_FETCH);
    add(0, 2'b01, 6'h00, 0, 4'd0, ST_NONE, SL_FETCH);
    add(0, 2'b01, 6'h00, 0, 4'd0, ST_NONE, SL_FETCH);
    add(0, 2'b01, 6'h00, 1, 4'd0, ST_FET,  SL_FETCH);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; Op = vecs[i].op; Funct = vecs[i].fn; MemReady = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_ctrl", i), 32'(observed()),
            32'({vecs[i].st, vecs[i].strb, vecs[i].sel}));
      exp_rs = {(vecs[i].op == 2'b01), (vecs[i].op == 2'b10)};
      check($sformatf("vec%0d_imm_regsrc", i), 32'({ImmSrc, RegSrc}),
            32'({vecs[i].op, exp_rs}));
      @(posedge clk); #1;
    end

    // Hand sequence: STR with 5 stall cycles, count MemW cycles and watch RegW.
    reset = 1'b1; MemReady = 1'b1; Op = 2'b01; Funct = 6'h00;
    @(posedge clk); #1;
    reset = 1'b0;
    memw_cnt = 0; regw_cnt = 0; cyc = 0;
    while (State != 4'd5 && cyc < 20) begin
      @(negedge clk); if (RegW) regw_cnt++;
      @(posedge clk); #1; cyc++;
    end
    check("str_reach_memwrite", 32'(cyc < 20), 32'd1);
    for (int k = 0; k < 6; k++) begin
      MemReady = (k == 5);
      @(negedge clk);
      if (MemW) memw_cnt++;
      if (RegW) regw_cnt++;
      @(posedge clk); #1;
    end
    check("str_memw_cycles", 32'(memw_cnt), 32'd6);
    check("str_back_to_fetch", 32'(State), 32'd0);
    @(negedge clk);
    check("str_no_memw_after", 32'(MemW), 32'd0);
    check("str_no_regw", 32'(regw_cnt), 32'd0);
    @(posedge clk); #1;

    // Hand sequence: undefined op, whole instruction free of write/branch strobes.
    Op = 2'b11; MemReady = 1'b1; bad_strobe = 1'b0; cyc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (RegW || MemW || Branch) bad_strobe = 1'b1;
      if (Undef) cyc++;
      @(posedge clk); #1;
    end
    check("undef_no_strobes", 32'(bad_strobe), 32'd0);
    check("undef_pulse_count", 32'(cyc), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multicycle ARMv4 datapath. It replaces single-cycle decoding with a Moore state machine. The machine steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects and write strobes. It sits between the instruction register (Op/Funct fields) and the shared datapath, and stalls on a single-ported instruction/data memory via a ready handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- Funct  in  6  instruction bits [25:20]; Funct[5] = I (immediate), Funct[0] = L (load)
- MemReady  in  1  memory has completed the current access this cycle
- IRWrite  out  1  load instruction register
- NextPC  out  1  load PC with ALU result
- Branch  out  1  branch state; PC load gated by CondEx outside this block
- RegW  out  1  register file write
- MemW  out  1  memory write
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALU direct
- ALUSrcA  out  1  0 = Rn, 1 = PC
- ALUSrcB  out  2  00 Rm/shifted, 01 ExtImm, 10 constant 4
- ALUOp  out  1  1 = use Funct-based ALU decode, 0 = add
- ImmSrc  out  2  equals Op (combinational)
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01) (combinational)
- Undef  out  1  pulses in DECODE when Op==11
- State  out  4  current state encoding, for debug

## Operation
States, in encoding order 0–9: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.

Transitions:
- FETCH: goes to DECODE when MemReady, else holds.
- DECODE:
  - Op=01 → MEMADR
  - Op=00 with Funct[5]=0 → EXECR
  - Op=00 with Funct[5]=1 → EXECI
  - Op=10 → BRANCH
  - Op=11 → FETCH, with Undef=1
- MEMADR: Funct[0]=1 → MEMREAD, else MEMWRITE.
- MEMREAD: goes to MEMWB when MemReady, else holds.
- MEMWRITE: goes to FETCH when MemReady, else holds.
- EXECR and EXECI: go to ALUWB.
- MEMWB, ALUWB and BRANCH: go to FETCH.

Outputs per state (unlisted strobes 0, unlisted selects 0):
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0; IRWrite=NextPC=MemReady
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0 (PC+8 read)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0
- MEMREAD: AdrSrc=1, ResultSrc=00
- MEMWB: ResultSrc=01, RegW=1
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1 for every cycle in state
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1
- ALUWB: ResultSrc=00, RegW=1
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1

Decode sampling: Op and Funct are sampled only in DECODE and MEMADR. The instruction register is stable from DECODE until the next FETCH.

## Timing
- Reset:
  - State register loads FETCH on the first edge with reset=1.
  - While reset=1, IRWrite, NextPC, RegW, MemW, Branch and Undef are forced to 0 combinationally.
  - Selects show FETCH values; State=0.
- Minimum latency with MemReady held 1:
  - B: 3 cycles
  - DP: 4 cycles
  - STR: 4 cycles
  - LDR: 5 cycles
  - Undefined: 2 cycles
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. No strobe repeats except MemW, which stays high until the ready cycle.
- reset asserted mid-instruction: abandons the instruction; no RegW/MemW in or after that cycle; FETCH next.
- reset deasserting: the first active cycle is FETCH.
- All outputs are combinational from State plus MemReady/Op/reset. No output-side registers.

## Structure
- Package multicycle_pkg:
  - typedef enum logic [3:0] ctrl_state_t (10 states, encodings above)
  - localparams for Op codes (OP_DP, OP_MEM, OP_B)
  - localparams for ResultSrc and ALUSrcB encodings
- Single module: state register, next-state logic and output decode. No sub-module is natural; ALU-function decode and condition checking stay in their existing blocks.

## Test plan
- Reset, then DP register instruction (Op=00, Funct=000000), MemReady=1:
  - State sequence 0,1,6,8,0
  - RegW=1 only in cycle 4
  - IRWrite=NextPC=1 only in cycle 1
- LDR (Op=01, Funct[0]=1) with MemReady=0 for 2 cycles in MEMREAD:
  - Sequence 0,1,2,3,3,3,4,0
  - ResultSrc=01 with RegW=1 once
- STR (Op=01, Funct[0]=0) with MemReady low 3 cycles in MEMWRITE:
  - MemW=1 for 4 consecutive cycles
  - Then FETCH; RegW never asserted
- Branch (Op=10):
  - Sequence 0,1,9,0
  - Branch=1, ALUSrcB=01 in state 9
  - ImmSrc=10, RegSrc=01 throughout
- Op=11:
  - Undef=1 for exactly one cycle in DECODE, then FETCH
  - No RegW/MemW/Branch asserted
- reset pulsed while in MEMWRITE:
  - MemW drops in the reset cycle
  - State=0 after the edge
  - FETCH with MemReady=0 holds with IRWrite=0
